ring_counter: RTL
=================

RING_COUNTER -- requirements
Module: ring_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: state width in bits, legal range 2..32.
REQ-002 SHALL provide parameter MODE, default 0: 0 = one-hot ring, 1 = Johnson (twisted ring).
REQ-003 SHALL provide port CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL provide port RESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL provide port CE, input, 1 bit: step enable.
REQ-006 SHALL provide port DIR, input, 1 bit: step direction, 0 = up, 1 = down.
REQ-007 SHALL provide port LOAD, input, 1 bit: synchronous parallel load.
REQ-008 SHALL provide port D, input, WIDTH bits: load data.
REQ-009 SHALL provide port O, output, WIDTH bits: registered counter state.
REQ-010 SHALL provide port TICK, output, 1 bit: registered wrap pulse.
REQ-011 SHALL provide port ERR, output, 1 bit: combinational illegal-state flag decoded from O.

Function
REQ-012 SHALL define the home state H as 1 (only bit 0 set) for MODE 0, and as all zeros for MODE 1.
REQ-013 SHALL, in MODE 0 with DIR=0, rotate left: O <= {O[WIDTH-2:0], O[WIDTH-1]}.
REQ-014 SHALL, in MODE 0 with DIR=1, rotate right: O <= {O[0], O[WIDTH-1:1]}.
REQ-015 SHALL, in MODE 1 with DIR=0, shift left with inversion: O <= {O[WIDTH-2:0], ~O[WIDTH-1]}.
REQ-016 SHALL, in MODE 1 with DIR=1, shift right with inversion: O <= {~O[0], O[WIDTH-1:1]}.
REQ-017 SHALL give a period of WIDTH steps in MODE 0 and 2*WIDTH steps in MODE 1.
REQ-018 SHALL apply this priority at each edge: LOAD=1 loads D regardless of CE or DIR; otherwise CE=1 steps; otherwise O holds.
REQ-019 SHALL accept any value of D on load, legal or not, unmodified.
REQ-020 SHALL set TICK to 1 on an edge only when a CE step, not a load, drives O to H; TICK SHALL be 0 on all other edges, so TICK is high during exactly the first cycle O shows H after a wrap.
REQ-021 SHALL decode a legal state in MODE 0 as exactly one bit set.
REQ-022 SHALL decode a legal state in MODE 1 as at most one index i in 0..WIDTH-2 with O[i] != O[i+1].
REQ-023 SHALL drive ERR = 1 whenever O is not legal, with zero-cycle latency.
REQ-024 SHALL apply a DIR change on the next enabled step, with no lost or extra step.

Reset
REQ-025 SHALL, while RESETN=0, asynchronously force O=H and TICK=0, with ERR=0 as a consequence.
REQ-026 SHALL, when reset is asserted mid-sequence, abandon the sequence; the first CE step after deassertion SHALL proceed from H.
REQ-027 SHALL NOT raise TICK on reset, nor on the first edge after reset deassertion unless a step reaches H.

Configuration
REQ-028 SHALL, when macro RING_COUNTER_SELF_CORRECT_EN is defined, make a CE step from an illegal state (LOAD=0) go to H instead of the shift, with TICK=0 on that edge.
REQ-029 SHALL, without RING_COUNTER_SELF_CORRECT_EN, shift illegal states per REQ-013..016; ERR behaviour is identical in both builds.

Verification
REQ-030 SHALL cover MODE 0, WIDTH=4: release reset, CE=1, DIR=0 for 4 edges -> O=0010,0100,1000,0001; TICK=1 only with the final 0001; ERR=0 throughout.
REQ-031 SHALL cover MODE 1, WIDTH=4: CE=1, DIR=0 for 8 edges -> O=0001,0011,0111,1111,1110,1100,1000,0000; TICK=1 only with 0000.
REQ-032 SHALL cover MODE 0, WIDTH=4: from 0001 step with DIR=1 -> 1000; then DIR=0 -> 0001 with TICK=1; then CE=0 for 3 edges -> O holds, TICK=0.
REQ-033 SHALL cover MODE 0: LOAD=1 with D=0101 -> O=0101, ERR=1, TICK=0; next CE step -> 0001 with macro, 1010 without.
REQ-034 SHALL cover MODE 1, WIDTH=4: at O=0111, assert RESETN=0 between edges -> O=0000 immediately, TICK=0; release, CE=1 -> 0001.
REQ-035 SHALL cover LOAD=1 with CE=1 and D=0001 (H) in MODE 0 -> O=0001, TICK=0.

Source files
------------

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot / Johnson ring counter with wrap tick and illegal-state flag.
// Define RING_COUNTER_SELF_CORRECT_EN to send CE steps from illegal states straight to home.
module ring_counter #(
   parameter int WIDTH = 4,
   parameter int MODE  = 0
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             CE,
   input  logic             DIR,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] O,
   output logic             TICK,
   output logic             ERR
);

   localparam logic             TWIST = (MODE == 1);
   localparam logic [WIDTH-1:0] HOME  = TWIST ? '0 : WIDTH'(1);

   logic [WIDTH-1:0] o_q;
   logic [WIDTH-1:0] o_d;
   logic [WIDTH-1:0] shift_val;
   logic [WIDTH-2:0] edge_vec;
   logic             tick_q;
   logic             tick_d;
   logic             legal;

   // Johnson states have at most one boundary between adjacent bits; one-hot has one bit set.
   always_comb begin
      edge_vec = o_q[WIDTH-1:1] ^ o_q[WIDTH-2:0];
      if (TWIST) begin
         legal = ((edge_vec & (edge_vec - (WIDTH-1)'(1))) == '0);
      end else begin
         legal = (o_q != '0) && ((o_q & (o_q - WIDTH'(1))) == '0);
      end
   end

   always_comb begin
      if (DIR) begin
         shift_val = {o_q[0] ^ TWIST, o_q[WIDTH-1:1]};
      end else begin
         shift_val = {o_q[WIDTH-2:0], o_q[WIDTH-1] ^ TWIST};
      end
   end

   always_comb begin
      o_d    = o_q;
      tick_d = 1'b0;
      if (LOAD) begin
         o_d = D;
      end else if (CE) begin
`ifdef RING_COUNTER_SELF_CORRECT_EN
         if (!legal) begin
            o_d = HOME;
         end else begin
            o_d    = shift_val;
            tick_d = (shift_val == HOME);
         end
`else
         o_d    = shift_val;
         tick_d = (shift_val == HOME);
`endif
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         o_q    <= HOME;
         tick_q <= 1'b0;
      end else begin
         o_q    <= o_d;
         tick_q <= tick_d;
      end
   end

   assign O    = o_q;
   assign TICK = tick_q;
   assign ERR  = ~legal;

endmodule
